// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
// Shared types and constants for the data-cache miss handler.
//   state_t      : fill FSM states (IDLE, FILL)
//   BLOCK_WORDS  : 16-bit words per cache block
//   WORD_IDX_W   : width of a word index within a block
//   MEM_LATENCY  : cycles from a read being issued to its response
//   OFFSET_W     : byte-offset bits covered by one block
// ----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int BLOCK_WORDS = 8;
    localparam int WORD_IDX_W  = 3;
    localparam int MEM_LATENCY = 4;
    localparam int OFFSET_W    = 4;

endpackage

// File: rtl/word_counter.sv
// ----------------------------------------------------------------------------
// word_counter
// Word-index counter for one block, wrapping modulo 2**WORD_IDX_W.
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   clr   in  synchronous clear (takes priority over en)
//   en    in  advance by one
//   count out current word index
// ----------------------------------------------------------------------------
module word_counter
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    output logic [WORD_IDX_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm
// Data-cache miss handler. On a miss it issues eight pipelined word reads
// covering the missing block, writes each response into the data array as it
// returns, and pulses the tag write with the last word. While idle it
// forwards write-through stores straight to memory in the same cycle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   miss_detected     miss level, held until fill_done
//   miss_address      byte address of the missing access
//   wr_req/addr/data  write-through store request
//   wr_ack            store forwarded to memory this cycle
//   fsm_busy          fill in progress (pipeline stall)
//   data_array_*      one-word write port into the cache data array
//   write_tag_array   tag/valid update pulse for the filled block
//   fill_done         fill complete pulse (same cycle as write_tag_array)
//   mem_*             memory request/response port
// ----------------------------------------------------------------------------
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [15:0]           wr_data,
    output logic                  wr_ack,
    output logic                  fsm_busy,
    output logic                  data_array_we,
    output logic [WORD_IDX_W-1:0] data_array_word,
    output logic [15:0]           data_array_data,
    output logic                  write_tag_array,
    output logic                  fill_done,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_data_valid
);

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(BLOCK_WORDS - 1);

    state_t                         state;
    state_t                         state_next;
    logic [ADDR_WIDTH-OFFSET_W-1:0] base;
    logic                           issue_done;
    logic [WORD_IDX_W-1:0]          issue_cnt;
    logic [WORD_IDX_W-1:0]          recv_cnt;
    logic                           accept_miss;
    logic                           issue_en;
    logic                           recv_en;

    // The byte offset of the missing access is irrelevant: the whole block is fetched.
    logic unused_offset;
    assign unused_offset = ^miss_address[OFFSET_W-1:0];

    assign accept_miss = (state == IDLE) && miss_detected;
    assign issue_en    = (state == FILL) && !issue_done;
    // Responses arriving while idle belong to no fill and are dropped.
    assign recv_en     = (state == FILL) && mem_data_valid;

    word_counter u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_miss),
        .en    (issue_en),
        .count (issue_cnt)
    );

    word_counter u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_miss),
        .en    (recv_en),
        .count (recv_cnt)
    );

    // State register plus the block base and the "all reads issued" flag.
    // issue_done is set on the 7->0 wrap so no ninth read is ever issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            issue_done <= 1'b0;
        end else begin
            state <= state_next;
            if (accept_miss) begin
                base       <= miss_address[ADDR_WIDTH-1:OFFSET_W];
                issue_done <= 1'b0;
            end else if (issue_en && (issue_cnt == LAST_WORD)) begin
                issue_done <= 1'b1;
            end
        end
    end

    // Next state and all outputs. Everything defaults to zero so unused
    // memory fields stay quiet. A miss in IDLE beats a pending store; the
    // store requester keeps wr_req up and is served after the fill.
    always_comb begin
        state_next      = state;
        wr_ack          = 1'b0;
        fsm_busy        = 1'b0;
        data_array_we   = 1'b0;
        data_array_word = '0;
        data_array_data = '0;
        write_tag_array = 1'b0;
        fill_done       = 1'b0;
        mem_enable      = 1'b0;
        mem_wr          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;

        unique case (state)
            IDLE: begin
                if (miss_detected) begin
                    state_next = FILL;
                end else if (wr_req) begin
                    mem_enable = 1'b1;
                    mem_wr     = 1'b1;
                    mem_addr   = wr_addr;
                    mem_wdata  = wr_data;
                    wr_ack     = 1'b1;
                end
            end

            FILL: begin
                fsm_busy = 1'b1;
                if (!issue_done) begin
                    mem_enable = 1'b1;
                    mem_addr   = {base, issue_cnt, 1'b0};
                end
                if (mem_data_valid) begin
                    data_array_we   = 1'b1;
                    data_array_word = recv_cnt;
                    data_array_data = mem_rdata;
                    // The final word completes the block, so the tag can go in now.
                    if (recv_cnt == LAST_WORD) begin
                        write_tag_array = 1'b1;
                        fill_done       = 1'b1;
                        state_next      = IDLE;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// ----------------------------------------------------------------------------
// tb_cache_fill_fsm
// Bench for cache_fill_fsm: a behavioural memory with a fixed response delay,
// a requester issuing misses and stores, and a reference model that
// describes each fill as "cycle k after the miss was taken".
// ----------------------------------------------------------------------------
module tb_cache_fill_fsm;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        fsm_busy;
    logic        data_array_we;
    logic [2:0]  data_array_word;
    logic [15:0] data_array_data;
    logic        write_tag_array;
    logic        fill_done;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;

    always #5 clk = ~clk;

    cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .miss_detected   (miss_detected),
        .miss_address    (miss_address),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_ack          (wr_ack),
        .fsm_busy        (fsm_busy),
        .data_array_we   (data_array_we),
        .data_array_word (data_array_word),
        .data_array_data (data_array_data),
        .write_tag_array (write_tag_array),
        .fill_done       (fill_done),
        .mem_enable      (mem_enable),
        .mem_wr          (mem_wr),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_data_valid  (mem_data_valid)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Memory contents as seen by the environment and as predicted by the model.
    logic [15:0] env_mem [0:32767];
    logic [15:0] ref_mem [0:32767];
    bit          pipe_v [MEM_LATENCY];
    logic [15:0] pipe_d [MEM_LATENCY];
    bit          stray;

    // Reference model: in a fill, m_k counts cycles since the miss was taken.
    bit          m_fill;
    int          m_k;
    logic [15:0] m_base;

    // Requester state.
    bit          pend_miss;
    bit          pend_wr;
    logic [15:0] pend_miss_addr;
    logic [15:0] pend_wr_addr;
    logic [15:0] pend_wr_data;
    logic [15:0] miss_q [$];
    logic [31:0] st_q [$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rnd, input bit do_rst);
        if (rnd) begin
            if (!pend_miss && miss_q.size() == 0 && $urandom_range(0, 9) == 0)
                miss_q.push_back(16'($urandom));
            if (!pend_wr && st_q.size() == 0 && $urandom_range(0, 3) == 0)
                st_q.push_back({16'($urandom) & 16'hFFFE, 16'($urandom)});
        end
        if (!pend_miss && miss_q.size() > 0) begin
            pend_miss      = 1'b1;
            pend_miss_addr = miss_q.pop_front();
        end
        if (!pend_wr && st_q.size() > 0) begin
            logic [31:0] s;
            s            = st_q.pop_front();
            pend_wr      = 1'b1;
            pend_wr_addr = s[31:16];
            pend_wr_data = s[15:0];
        end
        rst            = do_rst || (rnd && $urandom_range(0, 299) == 0);
        miss_detected  = pend_miss;
        miss_address   = pend_miss ? pend_miss_addr : 16'h0;
        wr_req         = pend_wr;
        wr_addr        = pend_wr ? pend_wr_addr : 16'h0;
        wr_data        = pend_wr ? pend_wr_data : 16'h0;
        mem_data_valid = pipe_v[MEM_LATENCY-1] | stray;
        mem_rdata      = pipe_d[MEM_LATENCY-1];
    endtask

    task automatic run_cycle(input bit rnd, input bit do_rst);
        bit          e_ack, e_en, e_wr, e_we, e_done;
        logic [15:0] e_addr, e_wdata, e_data;
        logic [2:0]  e_word;
        bit          c_en, c_wr;
        logic [15:0] c_addr, c_wdata;

        applyStimulus(rnd, do_rst);
        @(negedge clk);

        e_ack = 0; e_en = 0; e_wr = 0; e_we = 0; e_done = 0;
        e_addr = 0; e_wdata = 0; e_data = 0; e_word = 0;
        if (m_fill) begin
            if (m_k <= 8) begin
                e_en   = 1;
                e_addr = m_base + 16'(2 * (m_k - 1));
            end
            if (m_k >= 5) begin
                e_we   = 1;
                e_word = 3'(m_k - 5);
                e_data = ref_mem[int'(m_base[15:1]) + m_k - 5];
            end
            e_done = (m_k == 12);
        end else if (wr_req && !miss_detected) begin
            e_ack = 1; e_en = 1; e_wr = 1; e_addr = wr_addr; e_wdata = wr_data;
        end

        checkOutput("fsm_busy", 32'(fsm_busy), 32'(m_fill));
        checkOutput("wr_ack", 32'(wr_ack), 32'(e_ack));
        checkOutput("mem_enable", 32'(mem_enable), 32'(e_en));
        checkOutput("mem_wr", 32'(mem_wr), 32'(e_wr));
        checkOutput("mem_addr", 32'(mem_addr), 32'(e_addr));
        checkOutput("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        checkOutput("data_array_we", 32'(data_array_we), 32'(e_we));
        checkOutput("write_tag_array", 32'(write_tag_array), 32'(e_done));
        checkOutput("fill_done", 32'(fill_done), 32'(e_done));
        if (e_we) begin
            checkOutput("data_array_word", 32'(data_array_word), 32'(e_word));
            checkOutput("data_array_data", 32'(data_array_data), 32'(e_data));
        end

        c_en = mem_enable; c_wr = mem_wr; c_addr = mem_addr; c_wdata = mem_wdata;

        // Advance the model across the coming edge.
        if (rst) begin
            m_fill    = 0;
            pend_miss = 0;
            pend_wr   = 0;
        end else begin
            if (e_ack) begin
                ref_mem[wr_addr[15:1]] = wr_data;
                pend_wr = 0;
            end
            if (m_fill) begin
                if (m_k == 12) begin
                    m_fill    = 0;
                    pend_miss = 0;
                end else begin
                    m_k++;
                end
            end else if (miss_detected) begin
                m_fill = 1;
                m_k    = 1;
                m_base = {miss_address[15:4], 4'h0};
            end
        end

        @(posedge clk);
        #1;
        // Environment memory acts on what the DUT presented at that edge.
        if (rst) begin
            for (int i = 0; i < MEM_LATENCY; i++) pipe_v[i] = 0;
        end else begin
            for (int i = MEM_LATENCY - 1; i > 0; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_d[i] = pipe_d[i-1];
            end
            pipe_v[0] = c_en && !c_wr;
            pipe_d[0] = env_mem[c_addr[15:1]];
            if (c_en && c_wr) env_mem[c_addr[15:1]] = c_wdata;
        end
        stray = 0;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            env_mem[i] = 16'($urandom);
            ref_mem[i] = env_mem[i];
        end
        for (int i = 0; i < 8; i++) begin
            env_mem[16'h1230/2 + i] = 16'h00A0 + 16'(i);
            ref_mem[16'h1230/2 + i] = 16'h00A0 + 16'(i);
        end
        for (int i = 0; i < MEM_LATENCY; i++) begin
            pipe_v[i] = 0;
            pipe_d[i] = 0;
        end
        stray = 0; m_fill = 0; m_k = 0; m_base = 0;
        pend_miss = 0; pend_wr = 0;
        pend_miss_addr = 0; pend_wr_addr = 0; pend_wr_data = 0;
        rst = 1; miss_detected = 0; miss_address = 0;
        wr_req = 0; wr_addr = 0; wr_data = 0;
        mem_rdata = 0; mem_data_valid = 0;

        $display("[TB] reset and idle");
        @(posedge clk);
        #1;
        run_cycle(0, 1);
        checkOutput("reset_word", 32'(data_array_word), 32'h0);
        run_cycle(0, 0);
        stray = 1;
        run_cycle(0, 0);

        $display("[TB] single fill at 0x1236");
        miss_q.push_back(16'h1236);
        repeat (14) run_cycle(0, 0);

        $display("[TB] store then read back 0x0040");
        st_q.push_back({16'h0040, 16'hBEEF});
        repeat (2) run_cycle(0, 0);
        miss_q.push_back(16'h0040);
        repeat (14) run_cycle(0, 0);

        $display("[TB] miss and store together");
        miss_q.push_back(16'h0080);
        st_q.push_back({16'h0090, 16'h5A5A});
        repeat (15) run_cycle(0, 0);

        $display("[TB] reset during a fill");
        miss_q.push_back(16'h0300);
        repeat (6) run_cycle(0, 0);
        run_cycle(0, 1);
        miss_q.push_back(16'h0400);
        repeat (14) run_cycle(0, 0);

        $display("[TB] back-to-back misses");
        miss_q.push_back(16'h0100);
        miss_q.push_back(16'h0210);
        repeat (28) run_cycle(0, 0);

        $display("[TB] random traffic");
        repeat (2000) run_cycle(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
